mult_div_unit: RTL and testbench

Execute-stage multiply/divide unit. Sits beside the ALU between the D/E and E/M pipeline registers; its read port drives the E/M register's XALUOut input. Holds the architectural HI/LO registers and models the multi-cycle latency of MULT/DIV with a busy counter. The hazard unit uses this counter to stall the pipeline.

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mult_div_unit_calc.sv | 68 ++++++
 rtl/mult_div_unit.sv | 91 +++++++++
 tb/tb_mult_div_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encoding, default latencies, start-op decode.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU start ops.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  function automatic logic is_start_op(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_calc.sv
// Combinational result generator: computes the HI/LO value an op would produce from the current operands.
// MDU_MADD_EN adds the accumulate/subtract forms against {hi,lo}.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] pending_hi,
  output logic [31:0] pending_lo,
  output logic        write_en
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] den;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] mag_q;
  logic [31:0] mag_r;

  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 without a special case.
  assign den   = (b == 32'd0) ? 32'd1 : b;
  assign a_mag = a[31] ? (32'd0 - a) : a;
  assign b_mag = b[31] ? (32'd0 - b) : b;
  assign mag_q = a_mag / ((b_mag == 32'd0) ? 32'd1 : b_mag);
  assign mag_r = a_mag % ((b_mag == 32'd0) ? 32'd1 : b_mag);

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`endif

  always_comb begin
    pending_hi = hi;
    pending_lo = lo;
    write_en   = 1'b0;
    case (md_op)
      MD_MULT:  begin {pending_hi, pending_lo} = sprod; write_en = 1'b1; end
      MD_MULTU: begin {pending_hi, pending_lo} = uprod; write_en = 1'b1; end
      MD_DIV: begin
        pending_lo = (a[31] ^ b[31]) ? (32'd0 - mag_q) : mag_q;
        pending_hi = a[31] ? (32'd0 - mag_r) : mag_r;
        write_en   = (b != 32'd0);
      end
      MD_DIVU: begin
        pending_lo = a / den;
        pending_hi = a % den;
        write_en   = (b != 32'd0);
      end
      MD_MTHI: begin pending_hi = a; write_en = 1'b1; end
      MD_MTLO: begin pending_lo = a; write_en = 1'b1; end
`ifdef MDU_MADD_EN
      MD_MADD:  begin {pending_hi, pending_lo} = acc + sprod; write_en = 1'b1; end
      MD_MADDU: begin {pending_hi, pending_lo} = acc + uprod; write_en = 1'b1; end
      MD_MSUB:  begin {pending_hi, pending_lo} = acc - sprod; write_en = 1'b1; end
      MD_MSUBU: begin {pending_hi, pending_lo} = acc - uprod; write_en = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: HI/LO registers plus a busy counter modelling MULT/DIV latency.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] XALUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic [31:0]      pending_hi_reg;
  logic [31:0]      pending_lo_reg;
  logic             pending_we_reg;

  logic [31:0] hi_src;
  logic [31:0] lo_src;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_we;
  logic        last_cycle;
  logic        accept_start;
  logic        accept_move;

  assign last_cycle   = (cnt_reg == CNT_W'(1));
  assign accept_start = is_start_op(md_op) && ((cnt_reg == '0) || last_cycle);
  assign accept_move  = (cnt_reg == '0) && ((md_op == MD_MTHI) || (md_op == MD_MTLO));

  // A start on the final busy cycle must accumulate onto the result committing at the same edge.
  assign hi_src = (last_cycle && pending_we_reg) ? pending_hi_reg : hi_reg;
  assign lo_src = (last_cycle && pending_we_reg) ? pending_lo_reg : lo_reg;

  mdu_calc u_calc (
    .md_op      (md_op),
    .a          (A),
    .b          (B),
    .hi         (hi_src),
    .lo         (lo_src),
    .pending_hi (calc_hi),
    .pending_lo (calc_lo),
    .write_en   (calc_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      pending_hi_reg <= '0;
      pending_lo_reg <= '0;
      pending_we_reg <= 1'b0;
    end else begin
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (last_cycle && pending_we_reg) begin
          hi_reg <= pending_hi_reg;
          lo_reg <= pending_lo_reg;
        end
      end
      if (accept_start) begin
        cnt_reg        <= is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        pending_hi_reg <= calc_hi;
        pending_lo_reg <= calc_lo;
        pending_we_reg <= calc_we;
      end else if (accept_move) begin
        hi_reg <= calc_hi;
        lo_reg <= calc_lo;
      end
    end
  end

  assign busy    = (cnt_reg != '0);
  assign HI      = hi_reg;
  assign LO      = lo_reg;
  assign XALUOut = (md_op == MD_MFHI) ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: scoreboard queue of expected {HI,LO} popped when busy drops.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] XALUOut;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  mult_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .XALUOut (XALUOut),
    .HI      (HI),
    .LO      (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives a start op for one edge, optionally intrudes a second MULT at busy cycle `intrude`,
  // counts busy cycles, then pops the scoreboard and compares HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_cycles,
                        input int intrude);
    int n;
    logic [63:0] e;
    exp_q.push_back({exp_hi, exp_lo});
    md_op = op; A = a; B = b;
    @(negedge clk);
    md_op = MD_NONE;
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (n == intrude) begin md_op = MD_MULT; A = 32'd5; B = 32'd6; end
      else md_op = MD_NONE;
      @(negedge clk);
    end
    md_op = MD_NONE;
    e = exp_q.pop_front();
    check({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, "_hi"}, HI, e[63:32]);
    check({tag, "_lo"}, LO, e[31:0]);
    $display("txn %s op=%0d A=%h B=%h busy_cycles=%0d HI=%h LO=%h", tag, op, a, b, n, HI, LO);
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] a);
    md_op = op; A = a;
    @(negedge clk);
    md_op = MD_NONE;
    $display("txn move op=%0d A=%h HI=%h LO=%h", op, a, HI, LO);
  endtask

  initial begin
    int n;
    reset = 1'b1; md_op = MD_NONE; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_xalu", XALUOut, 32'd0);

    run_op("mult",  MD_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 0);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 0);
    run_op("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
    run_op("divu",  MD_DIVU,  32'd7,        32'd2, 32'd1,        32'd3,        10, 0);
    run_op("divov", MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 0);

    move(MD_MTHI, 32'h1234);
    md_op = MD_MFHI; #1;
    check("mfhi", XALUOut, 32'h1234);
    md_op = MD_MFLO; #1;
    check("mflo", XALUOut, 32'h80000000);
    @(negedge clk);
    md_op = MD_NONE;

    run_op("busy_ign", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, 2);

    move(MD_MTLO, 32'h55);
    run_op("div0", MD_DIV, 32'd9, 32'd0, 32'd0, 32'h55, 10, 0);

    // Reset on the third busy cycle of a DIV discards the in-flight result.
    md_op = MD_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    md_op = MD_NONE;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_hi", HI, 32'd0);
    check("rstmid_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    check("rstmid_late_hi", HI, 32'd0);
    check("rstmid_late_lo", LO, 32'd0);
    $display("txn reset_mid_div busy=%0d HI=%h LO=%h", busy, HI, LO);

    move(MD_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", MD_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
`else
    run_op("maddu", MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0, 0);
`endif

    // Back-to-back: second start on the final busy cycle of the first.
    exp_q.push_back({32'd0, 32'd6});
    exp_q.push_back({32'd0, 32'd20});
    md_op = MD_MULTU; A = 32'd2; B = 32'd3;
    @(negedge clk);
    md_op = MD_NONE;
    repeat (4) @(negedge clk);
    md_op = MD_MULTU; A = 32'd4; B = 32'd5;
    @(negedge clk);
    md_op = MD_NONE;
    begin
      logic [63:0] e;
      e = exp_q.pop_front();
      check("b2b_first_lo", LO, e[31:0]);
      check("b2b_busy", 32'(busy), 32'd1);
      n = 0;
      while (busy && n < 50) begin n++; @(negedge clk); end
      e = exp_q.pop_front();
      check("b2b_cycles", 32'(n), 32'd5);
      check("b2b_second_lo", LO, e[31:0]);
      $display("txn b2b HI=%h LO=%h", HI, LO);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
